// File: rtl/bit_serial_addsub_if.sv
// Handshake and operand/result bundle for bit_serial_addsub.
interface bit_serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cy_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, cy_in,
    input  busy, done, sum, cy_out, ovf
  );

  modport slave (
    input  start, sub, a, b, cy_in,
    output busy, done, sum, cy_out, ovf
  );
endinterface

// File: rtl/bit_serial_addsub.sv
// WIDTH-bit bit-serial add/subtract, LSB first, one full-adder slice, latency WIDTH+1.
// Define BSA_OVF_EN to register signed overflow; otherwise ovf is tied low.
module bit_serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  bit_serial_addsub_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_full;
  logic             carry, cy_q;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_next, last, accept;

  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last     = (cnt == CW'(WIDTH - 1));
    accept   = bus.start && (state_q != RUN);
    // acc keeps only the upper WIDTH-1 result bits; the newest bit completes the word
    acc_full = {s_bit, acc};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.cy_in ^ bus.sub;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      acc   <= acc_full[WIDTH-1:1];
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_next;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_q <= acc_full;
        cy_q  <= c_next;
      end
    end
  end

  assign bus.sum    = sum_q;
  assign bus.cy_out = cy_q;

`ifdef BSA_OVF_EN
  logic ovf_q;

  // carry still holds the carry into the MSB during the final RUN cycle
  always_ff @(posedge clk) begin
    if (rst)                           ovf_q <= 1'b0;
    else if (state_q == RUN && last)   ovf_q <= carry ^ c_next;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub: WIDTH=8 and WIDTH=16 instances.
module tb_bit_serial_addsub;
`ifdef BSA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_addsub_if #(.WIDTH(8))  i8 ();
  bit_serial_addsub_if #(.WIDTH(16)) i16 ();

  bit_serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
  bit_serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic        sel = 1'b0;
  logic [15:0] prev_sum = '0;
  logic        prev_co = 1'b0;
  logic        prev_ov = 1'b0;

  logic [15:0] cur_sum;
  logic        cur_busy, cur_done, cur_co, cur_ov;
  assign cur_sum  = sel ? i16.sum    : {8'h00, i8.sum};
  assign cur_busy = sel ? i16.busy   : i8.busy;
  assign cur_done = sel ? i16.done   : i8.done;
  assign cur_co   = sel ? i16.cy_out : i8.cy_out;
  assign cur_ov   = sel ? i16.ovf    : i8.ovf;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int unsigned w, input logic s, input logic [15:0] av,
                                input logic [15:0] bv, input logic c, output logic [15:0] es,
                                output logic eco, output logic eov);
    longint lim, ua, ub, sa, sb, t, r;
    lim = longint'(1) << (w - 1);
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (s) begin
      t   = ua - ub - longint'(c);
      eco = (ua >= ub + longint'(c));
      r   = sa - sb - longint'(c);
    end else begin
      t   = ua + ub + longint'(c);
      eco = (t >= 2 * lim);
      r   = sa + sb + longint'(c);
    end
    es  = 16'(t & (2 * lim - 1));
    eov = OVF_EN && ((r >= lim) || (r < -lim));
  endfunction

  task automatic drive(input logic st, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic c);
    if (sel) begin
      i16.start = st; i16.sub = s; i16.a = av; i16.b = bv; i16.cy_in = c;
    end else begin
      i8.start = st; i8.sub = s; i8.a = av[7:0]; i8.b = bv[7:0]; i8.cy_in = c;
    end
  endtask

  // Called just after a rising edge; leaves the bench in the done cycle (or one after if gap).
  task automatic op(input logic s, input logic [15:0] av, input logic [15:0] bv, input logic c,
                    input logic [15:0] es, input logic eco, input logic eov,
                    input bit disturb, input bit gap);
    int unsigned w;
    w = sel ? 16 : 8;
    drive(1'b1, s, av, bv, c);
    @(posedge clk);
    for (int unsigned i = 0; i < w; i++) begin
      #1;
      chk("busy_run", {31'd0, cur_busy}, 32'd1);
      chk("done_run", {31'd0, cur_done}, 32'd0);
      chk("sum_held", {16'd0, cur_sum}, {16'd0, prev_sum});
      chk("flags_held", {30'd0, cur_co, cur_ov}, {30'd0, prev_co, prev_ov});
      if (disturb)
        drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      else
        drive(1'b0, s, av, bv, c);
      @(posedge clk);
    end
    #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("done_pulse", {30'd0, cur_done, cur_busy}, 32'd2);
    chk("sum", {16'd0, cur_sum}, {16'd0, es});
    chk("cy_out", {31'd0, cur_co}, {31'd0, eco});
    chk("ovf", {31'd0, cur_ov}, {31'd0, eov});
    prev_sum = es;
    prev_co  = eco;
    prev_ov  = eov;
    if (gap) begin
      @(posedge clk);
      #1;
      chk("done_one_cycle", {30'd0, cur_done, cur_busy}, 32'd0);
      chk("sum_after_done", {16'd0, cur_sum}, {16'd0, prev_sum});
    end
  endtask

  task automatic rand_op(input bit disturb, input bit gap);
    logic [15:0] av, bv, mask, es;
    logic        s, c, eco, eov;
    mask = sel ? 16'hFFFF : 16'h00FF;
    av   = 16'($urandom) & mask;
    bv   = 16'($urandom) & mask;
    s    = 1'($urandom);
    c    = 1'($urandom);
    model(sel ? 16 : 8, s, av, bv, c, es, eco, eov);
    op(s, av, bv, c, es, eco, eov, disturb, gap);
  endtask

  vec_t vecs[9];
  logic saw_done;

  initial begin
    vecs[0] = '{1'b0, 16'h5A, 16'h33, 1'b0, 16'h8D, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h01, 16'h01, 1'b1, 16'h03, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h10, 16'h01, 1'b0, 16'h0F, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h01, 16'h02, 1'b0, 16'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h05, 16'h02, 1'b1, 16'h02, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 16'h10, 16'h10, 1'b0, 16'h20, 1'b0, 1'b0};

    sel = 1'b1; drive(1'b0, 1'b0, '0, '0, 1'b0);
    sel = 1'b0; drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst8", {13'd0, i8.busy, i8.done, i8.cy_out, i8.ovf, 7'd0, i8.sum}, 32'd0);
    chk("rst16", {12'd0, i16.busy, i16.done, i16.cy_out, i16.ovf, i16.sum}, 32'd0);
    rst = 1'b0;

    // Directed vectors issued back-to-back from each done cycle.
    for (int i = 0; i < 9; i++)
      op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].es, vecs[i].eco,
         OVF_EN & vecs[i].eov, 1'b0, i == 8);

    for (int i = 0; i < 30; i++)
      rand_op(1'b1, 1'($urandom));
    rand_op(1'b0, 1'b1);

    // Reset during RUN cycle 4 aborts without a done pulse.
    drive(1'b1, 1'b0, 16'h0F, 16'h0F, 1'b0);
    @(posedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_state", {30'd0, cur_busy, cur_done}, 32'd0);
    chk("abort_sum", {16'd0, cur_sum}, 32'd0);
    chk("abort_flags", {30'd0, cur_co, cur_ov}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | cur_done | cur_busy;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    prev_sum = '0; prev_co = 1'b0; prev_ov = 1'b0;

    sel = 1'b1;
    rand_op(1'b1, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      rand_op(1'b1, 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
